dac_sample_selector: RTL and testbench

//  Upstream feeder for each DAC output channel. Watches the deserialized amplifier sample stream
//  and captures the one word addressed by (stream, channel) for the DAC. Also averages a masked set
//  of channels into a software reference. Hands both to the DAC/HPF stage as frame-stable values
//  (offset binary). Outputs update once per frame, so the DAC SPI sequence never sees a mid-frame change.

---
 rtl/rhythm_dac_pkg.sv | 44 ++++
 rtl/dac_sample_selector_ref_accumulator.sv | 56 +++++
 rtl/dac_sample_selector.sv | 144 ++++++++++++++
 tb/tb_dac_sample_selector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rhythm_dac_pkg.sv
// Shared types, widths and sample-format helpers for the DAC feeder path.
package rhythm_dac_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 22;
  localparam int CNT_W    = 6;

  localparam logic [SAMPLE_W-1:0] MIDSCALE  = 16'h8000;
  localparam logic [2:0]          MAX_SHIFT = 3'd5;

  // Two's-complement bounds of a 16-bit result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_HI = 22'sh007FFF;
  localparam logic signed [ACC_W-1:0] SAT_LO = 22'sh3F8000;

  // Per-frame configuration, captured on frame_start.
  typedef struct packed {
    logic [4:0]  dac_stream;
    logic [5:0]  dac_channel;
    logic [4:0]  ref_stream;
    logic [31:0] ref_mask;
    logic [2:0]  ref_shift;
  } snap_t;

  // Offset binary and two's complement differ only in the MSB.
  function automatic logic signed [SAMPLE_W-1:0] offset_to_twos(input logic [SAMPLE_W-1:0] x);
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction

  function automatic logic [SAMPLE_W-1:0] twos_to_offset(input logic signed [SAMPLE_W-1:0] x);
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction

  // Clamp a wide signed value into the 16-bit two's-complement range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
    if (x > SAT_HI) begin
      return 16'h7FFF;
    end else if (x < SAT_LO) begin
      return 16'h8000;
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dac_sample_selector_ref_accumulator.sv
// Reference-channel accumulator: sums offset-binary samples as signed values,
// counts them, and presents the shifted, saturated average.
module ref_accumulator
  import rhythm_dac_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       add_i,
  input  logic [SAMPLE_W-1:0]        data_i,
  input  logic [2:0]                 shift_i,
  output logic signed [SAMPLE_W-1:0] result16_o,
  output logic [CNT_W-1:0]           cnt_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0] sample_twos;
  logic signed [ACC_W-1:0]    sample_ext;
  logic signed [ACC_W-1:0]    acc_shifted;

  assign sample_twos = offset_to_twos(data_i);
  assign sample_ext  = {{(ACC_W-SAMPLE_W){sample_twos[SAMPLE_W-1]}}, sample_twos};

  // Next-state: clear first, then add, so a sample on the clear cycle opens the new sum.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (add_i) begin
      acc_d = acc_d + sample_ext;
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_shifted = acc_q >>> shift_i;
  assign result16_o  = sat16(acc_shifted);
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/dac_sample_selector.sv
// Picks one (stream, channel) word per frame for the DAC and averages a masked
// channel set into a software reference; both are committed once per frame.
module dac_sample_selector
  import rhythm_dac_pkg::*;
#(
  parameter int N_STREAMS  = 32,
  parameter int N_CHANNELS = 35
) (
  input  logic                dataclk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                sample_valid,
  input  logic [4:0]          sample_stream,
  input  logic [5:0]          sample_channel,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [4:0]          dac_stream_sel,
  input  logic [5:0]          dac_channel_sel,
  input  logic [4:0]          ref_stream_sel,
  input  logic [31:0]         ref_mask,
  input  logic [2:0]          ref_shift,
  output logic [SAMPLE_W-1:0] dac_sample,
  output logic [SAMPLE_W-1:0] software_reference,
  output logic                sample_update,
  output logic                sample_missing,
  output logic [CNT_W-1:0]    ref_count
);

  localparam logic [5:0] STREAM_LIMIT  = 6'(N_STREAMS);
  localparam logic [5:0] CHANNEL_LIMIT = 6'(N_CHANNELS);

  snap_t snap_q, snap_in, snap_eff;

  logic                       hit_q, hit_d;
  logic [SAMPLE_W-1:0]        shadow_q, shadow_d;
  logic [SAMPLE_W-1:0]        dac_q, dac_d;
  logic [SAMPLE_W-1:0]        sref_q, sref_d;
  logic                       update_q;
  logic                       missing_q, missing_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic                       stream_ok, channel_ok;
  logic                       dac_match, ref_match;
  logic signed [SAMPLE_W-1:0] acc_result;
  logic [CNT_W-1:0]           acc_cnt;

  // Live config as it would be snapshotted; oversize shifts fold to the maximum.
  always_comb begin
    snap_in.dac_stream  = dac_stream_sel;
    snap_in.dac_channel = dac_channel_sel;
    snap_in.ref_stream  = ref_stream_sel;
    snap_in.ref_mask    = ref_mask;
    snap_in.ref_shift   = (ref_shift > MAX_SHIFT) ? MAX_SHIFT : ref_shift;
  end

  // A sample on the frame_start cycle belongs to the new frame, so it sees the new config.
  assign snap_eff = frame_start ? snap_in : snap_q;

  assign stream_ok  = {1'b0, sample_stream} < STREAM_LIMIT;
  assign channel_ok = sample_channel < CHANNEL_LIMIT;

  assign dac_match = sample_valid && stream_ok && channel_ok
                  && (sample_stream == snap_eff.dac_stream)
                  && (sample_channel == snap_eff.dac_channel);

  // Only amplifier channels 0..31 can be reference members.
  assign ref_match = sample_valid && stream_ok && !sample_channel[5]
                  && (sample_stream == snap_eff.ref_stream)
                  && snap_eff.ref_mask[sample_channel[4:0]];

  // The commit uses the shift of the frame being closed, not the incoming one.
  ref_accumulator u_ref_acc (
    .clk        (dataclk),
    .reset      (reset),
    .clear_i    (frame_start),
    .add_i      (ref_match),
    .data_i     (sample_data),
    .shift_i    (snap_q.ref_shift),
    .result16_o (acc_result),
    .cnt_o      (acc_cnt)
  );

  // Capture shadow: cleared at frame boundary, last matching sample in a frame wins.
  always_comb begin
    hit_d    = hit_q;
    shadow_d = shadow_q;
    if (frame_start) begin
      hit_d = 1'b0;
    end
    if (dac_match) begin
      hit_d    = 1'b1;
      shadow_d = sample_data;
    end
  end

  // Frame commit: publish the closed frame's capture and reference average.
  always_comb begin
    dac_d     = dac_q;
    sref_d    = sref_q;
    missing_d = missing_q;
    count_d   = count_q;
    if (frame_start) begin
      if (hit_q) begin
        dac_d     = shadow_q;
        missing_d = 1'b0;
      end else begin
        missing_d = 1'b1;
      end
      sref_d  = (acc_cnt == '0) ? MIDSCALE : twos_to_offset(acc_result);
      count_d = acc_cnt;
    end
  end

  // Snapshot, shadow and output registers with synchronous reset.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      snap_q    <= '0;
      hit_q     <= 1'b0;
      shadow_q  <= '0;
      dac_q     <= MIDSCALE;
      sref_q    <= MIDSCALE;
      update_q  <= 1'b0;
      missing_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (frame_start) begin
        snap_q <= snap_in;
      end
      hit_q     <= hit_d;
      shadow_q  <= shadow_d;
      dac_q     <= dac_d;
      sref_q    <= sref_d;
      update_q  <= frame_start;
      missing_q <= missing_d;
      count_q   <= count_d;
    end
  end

  assign dac_sample         = dac_q;
  assign software_reference = sref_q;
  assign sample_update      = update_q;
  assign sample_missing     = missing_q;
  assign ref_count          = count_q;

endmodule

// File: tb/tb_dac_sample_selector.sv
// Directed bench for dac_sample_selector with hand-computed expectations.
module tb_dac_sample_selector;

  logic        dataclk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        sample_valid;
  logic [4:0]  sample_stream;
  logic [5:0]  sample_channel;
  logic [15:0] sample_data;
  logic [4:0]  dac_stream_sel;
  logic [5:0]  dac_channel_sel;
  logic [4:0]  ref_stream_sel;
  logic [31:0] ref_mask;
  logic [2:0]  ref_shift;
  logic [15:0] dac_sample;
  logic [15:0] software_reference;
  logic        sample_update;
  logic        sample_missing;
  logic [5:0]  ref_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 dataclk = ~dataclk;

  dac_sample_selector dut (
    .dataclk            (dataclk),
    .reset              (reset),
    .frame_start        (frame_start),
    .sample_valid       (sample_valid),
    .sample_stream      (sample_stream),
    .sample_channel     (sample_channel),
    .sample_data        (sample_data),
    .dac_stream_sel     (dac_stream_sel),
    .dac_channel_sel    (dac_channel_sel),
    .ref_stream_sel     (ref_stream_sel),
    .ref_mask           (ref_mask),
    .ref_shift          (ref_shift),
    .dac_sample         (dac_sample),
    .software_reference (software_reference),
    .sample_update      (sample_update),
    .sample_missing     (sample_missing),
    .ref_count          (ref_count)
  );

  task automatic tick();
    @(posedge dataclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [4:0] s, input logic [5:0] c, input logic [15:0] d);
    sample_valid   = 1'b1;
    sample_stream  = s;
    sample_channel = c;
    sample_data    = d;
    tick();
    sample_valid   = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_commit(input string tag, input logic [15:0] dac, input logic miss,
                              input logic [15:0] sref, input logic [5:0] cnt);
    check({tag, ".upd"},  32'(sample_update),      32'd1);
    check({tag, ".dac"},  32'(dac_sample),         32'(dac));
    check({tag, ".miss"}, 32'(sample_missing),     32'(miss));
    check({tag, ".sref"}, 32'(software_reference), 32'(sref));
    check({tag, ".cnt"},  32'(ref_count),          32'(cnt));
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; sample_valid = 1'b0;
    sample_stream = '0; sample_channel = '0; sample_data = '0;
    dac_stream_sel = '0; dac_channel_sel = '0; ref_stream_sel = '0;
    ref_mask = '0; ref_shift = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst.dac",  32'(dac_sample),         32'h8000);
    check("rst.sref", 32'(software_reference), 32'h8000);
    check("rst.upd",  32'(sample_update),      32'd0);
    check("rst.miss", 32'(sample_missing),     32'd0);
    check("rst.cnt",  32'(ref_count),          32'd0);

    // 1: empty frames, one update pulse each
    for (int i = 0; i < 3; i++) begin
      frame();
      check_commit("empty", 16'h8000, 1'b1, 16'h8000, 6'd0);
      tick();
      check("empty.upd_low", 32'(sample_update), 32'd0);
    end

    // 2: capture stream 2 channel 7
    dac_stream_sel = 5'd2; dac_channel_sel = 6'd7;
    frame();
    sample(5'd2, 6'd6, 16'h1111);
    sample(5'd3, 6'd7, 16'h2222);
    sample(5'd2, 6'd7, 16'h9234);
    tick();
    frame();
    check_commit("cap", 16'h9234, 1'b0, 16'h8000, 6'd0);

    // 3: reference average of four channels, shift 2 -> 1000/4 = 250
    ref_stream_sel = 5'd4; ref_mask = 32'h0000_000F; ref_shift = 3'd2;
    frame();
    check_commit("hold", 16'h9234, 1'b1, 16'h8000, 6'd0);
    sample(5'd4, 6'd0, 16'h8064);
    sample(5'd4, 6'd1, 16'h80C8);
    sample(5'd4, 6'd2, 16'h812C);
    sample(5'd4, 6'd3, 16'h8190);
    sample(5'd4, 6'd5, 16'hFFFF);
    sample(5'd3, 6'd1, 16'hFFFF);
    frame();
    check_commit("ref4", 16'h9234, 1'b1, 16'h80FA, 6'd4);

    // 4: saturation high and low
    ref_mask = 32'h0000_00FF; ref_shift = 3'd0;
    frame();
    for (int c = 0; c < 8; c++) sample(5'd4, 6'(c), 16'hF000);
    frame();
    check_commit("sat_hi", 16'h9234, 1'b1, 16'hFFFF, 6'd8);
    for (int c = 0; c < 8; c++) sample(5'd4, 6'(c), 16'h1000);
    frame();
    check_commit("sat_lo", 16'h9234, 1'b1, 16'h0000, 6'd8);

    // Shift 7 folds to 5; channel 33 aliases bit 1 but must be ignored
    ref_mask = 32'hFFFF_FFFF; ref_shift = 3'd7;
    frame();
    for (int c = 0; c < 32; c++) sample(5'd4, 6'(c), 16'h8020);
    sample(5'd4, 6'd33, 16'hF000);
    frame();
    check_commit("shift_clamp", 16'h9234, 1'b1, 16'h8020, 6'd32);

    // 5: mid-frame select change, duplicate last-wins, coincident sample
    frame();
    sample(5'd2, 6'd7, 16'hA000);
    sample(5'd2, 6'd7, 16'hA111);
    dac_channel_sel = 6'd9;
    sample(5'd2, 6'd9, 16'hB222);
    sample_valid = 1'b1; sample_stream = 5'd2; sample_channel = 6'd9; sample_data = 16'hC333;
    frame();
    sample_valid = 1'b0;
    check_commit("midsel", 16'hA111, 1'b0, 16'h8000, 6'd0);
    dac_channel_sel = 6'd40;
    tick();
    frame();
    check_commit("coinc", 16'hC333, 1'b0, 16'h8000, 6'd0);
    sample(5'd2, 6'd40, 16'hD000);
    frame();
    check_commit("chan_oob", 16'hC333, 1'b1, 16'h8000, 6'd0);

    // 6: reset in the middle of a frame
    dac_channel_sel = 6'd7;
    frame();
    sample(5'd2, 6'd7, 16'hE555);
    sample(5'd4, 6'd0, 16'hF000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst.dac",  32'(dac_sample),         32'h8000);
    check("mrst.sref", 32'(software_reference), 32'h8000);
    check("mrst.miss", 32'(sample_missing),     32'd0);
    check("mrst.cnt",  32'(ref_count),          32'd0);
    tick(); tick();
    check("mrst.upd",  32'(sample_update),      32'd0);
    frame();
    check_commit("post_rst", 16'h8000, 1'b1, 16'h8000, 6'd0);
    sample(5'd2, 6'd7, 16'hF00D);
    sample(5'd4, 6'd0, 16'h8040);
    frame();
    check_commit("post_rst2", 16'hF00D, 1'b0, 16'h8002, 6'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
